// File: rtl/pc_fetch_ctrl.sv
// Program-counter and instruction-fetch controller for the monocycle RISC-V core.
// Holds the architectural PC, runs the imem fetch handshake, presents the
// fetched instruction to decode, commits the selected next PC on ack, traps
// misaligned targets and counts retired instructions.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ack,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign_trap,
    output logic [31:0] trap_pc,
    output logic [31:0] trap_val,
    output logic [63:0] instret
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 64;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   capture;
    logic   commit;
    logic   misaligned;

    // Target alignment and the PC+4 adder feeding the next-PC mux
    assign misaligned = (next_pc[1:0] != 2'b00);
    assign imem_addr  = pc;
    assign pc_plus4   = pc + XLEN'(4);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode; imem_req is held low while in reset
    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        capture     = 1'b0;
        commit      = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = rst_n;
                if (imem_ready) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (instr_ack) begin
                    commit  = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Instruction capture, PC commit, trap capture and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            instr         <= NOP_INSTR;
            misalign_trap <= 1'b0;
            trap_pc       <= '0;
            trap_val      <= '0;
            instret       <= '0;
        end else begin
            misalign_trap <= 1'b0;
            if (capture) begin
                instr <= imem_rdata;
            end
            if (commit) begin
                instret <= instret + CNT_W'(1);
                if (misaligned) begin
                    pc            <= TRAP_VEC;
                    trap_pc       <= pc;
                    trap_val      <= next_pc;
                    misalign_trap <= 1'b1;
                end else begin
                    pc <= next_pc;
                end
            end
        end
    end

endmodule
